// File: rtl/voice_allocator.sv
// Four-voice note allocator: retrigger, lowest free voice, else steal the oldest.
// Each event is scanned one voice per cycle, then applied in a single edge.
module voice_allocator (
    input  logic        IN_CLOCK,
    input  logic        IN_RESET,
    input  logic        IN_EVT_VALID,
    output logic        IN_EVT_READY,
    input  logic        IN_EVT_NOTEON,
    input  logic [6:0]  IN_EVT_NOTE,
    input  logic [6:0]  IN_EVT_VEL,
    input  logic        IN_ALL_OFF,
    output logic [3:0]  OUT_ACTIVE,
    output logic [27:0] OUT_NOTE,
    output logic [27:0] OUT_VEL,
    output logic [3:0]  OUT_TRIGGER,
    output logic        OUT_STEAL,
    output logic [2:0]  OUT_COUNT
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        APPLY
    } state_t;

    state_t     state_q;
    logic       on_q;
    logic [6:0] note_q;
    logic [6:0] vel_q;
    logic [1:0] idx_q;
    logic       hit_q;
    logic       free_q;
    logic [1:0] hit_idx_q;
    logic [1:0] free_idx_q;

    logic [3:0] act_q;
    logic [6:0] vnote_q [4];
    logic [6:0] vvel_q  [4];
    logic [1:0] rank_q  [4];
    logic [3:0] trig_q;
    logic       steal_q;
    logic [2:0] count_q;

    logic       scan_hit;
    logic       scan_free;
    logic [1:0] old_idx;
    logic [1:0] tgt;
    logic [3:0] off_mask;
    logic [3:0] act_d;

    function automatic logic [2:0] popcnt(input logic [3:0] a);
        popcnt = 3'(a[0]) + 3'(a[1]) + 3'(a[2]) + 3'(a[3]);
    endfunction

    assign IN_EVT_READY = (state_q == IDLE);

    assign scan_hit  = act_q[idx_q] && (vnote_q[idx_q] == note_q);
    assign scan_free = !act_q[idx_q];

    always_comb begin
        old_idx  = 2'd0;
        off_mask = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            if (rank_q[v] == 2'd3) begin
                old_idx = 2'(v);
            end
            off_mask[v] = act_q[v] && (vnote_q[v] == note_q);
        end
        if (hit_q) begin
            tgt = hit_idx_q;
        end else if (free_q) begin
            tgt = free_idx_q;
        end else begin
            tgt = old_idx;
        end
        if (on_q) begin
            act_d = act_q | (4'b0001 << tgt);
        end else begin
            act_d = act_q & ~off_mask;
        end
    end

    always_comb begin
        OUT_NOTE = '0;
        OUT_VEL  = '0;
        for (int v = 0; v < 4; v++) begin
            OUT_NOTE[7*v +: 7] = vnote_q[v];
            OUT_VEL[7*v +: 7]  = vvel_q[v];
        end
    end

    assign OUT_ACTIVE  = act_q;
    assign OUT_TRIGGER = trig_q;
    assign OUT_STEAL   = steal_q;
    assign OUT_COUNT   = count_q;

    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            state_q    <= IDLE;
            on_q       <= 1'b0;
            note_q     <= '0;
            vel_q      <= '0;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            free_q     <= 1'b0;
            hit_idx_q  <= '0;
            free_idx_q <= '0;
            act_q      <= '0;
            trig_q     <= '0;
            steal_q    <= 1'b0;
            count_q    <= '0;
            for (int v = 0; v < 4; v++) begin
                vnote_q[v] <= '0;
                vvel_q[v]  <= '0;
                rank_q[v]  <= 2'(v);
            end
        end else begin
            trig_q  <= '0;
            steal_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // All-off wins over a simultaneous event, which is dropped
                    if (IN_ALL_OFF) begin
                        act_q   <= '0;
                        count_q <= '0;
                    end else if (IN_EVT_VALID) begin
                        on_q    <= IN_EVT_NOTEON && (IN_EVT_VEL != 7'd0);
                        note_q  <= IN_EVT_NOTE;
                        vel_q   <= IN_EVT_VEL;
                        idx_q   <= '0;
                        hit_q   <= 1'b0;
                        free_q  <= 1'b0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_hit && !hit_q) begin
                        hit_q     <= 1'b1;
                        hit_idx_q <= idx_q;
                    end
                    if (scan_free && !free_q) begin
                        free_q     <= 1'b1;
                        free_idx_q <= idx_q;
                    end
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    if (on_q) begin
                        vnote_q[tgt] <= note_q;
                        vvel_q[tgt]  <= vel_q;
                        trig_q[tgt]  <= 1'b1;
                        steal_q      <= !hit_q && !free_q;
                        for (int v = 0; v < 4; v++) begin
                            if (2'(v) == tgt) begin
                                rank_q[v] <= 2'd0;
                            end else if (rank_q[v] < rank_q[tgt]) begin
                                rank_q[v] <= rank_q[v] + 2'd1;
                            end
                        end
                    end
                    act_q   <= act_d;
                    count_q <= popcnt(act_d);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: stimulus queues expected table snapshots,
// a monitor compares them on the cycle each event or reset should land.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic        noteon;
    logic [6:0]  note;
    logic [6:0]  vel;
    logic        all_off;
    logic [3:0]  active;
    logic [27:0] onote;
    logic [27:0] ovel;
    logic [3:0]  trig;
    logic        steal;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  act;
        logic [27:0] note;
        logic [27:0] vel;
        logic [3:0]  trig;
        logic        steal;
        logic [2:0]  cnt;
    } exp_t;

    exp_t q[$];

    voice_allocator dut (
        .IN_CLOCK     (clk),
        .IN_RESET     (rst),
        .IN_EVT_VALID (valid),
        .IN_EVT_READY (ready),
        .IN_EVT_NOTEON(noteon),
        .IN_EVT_NOTE  (note),
        .IN_EVT_VEL   (vel),
        .IN_ALL_OFF   (all_off),
        .OUT_ACTIVE   (active),
        .OUT_NOTE     (onote),
        .OUT_VEL      (ovel),
        .OUT_TRIGGER  (trig),
        .OUT_STEAL    (steal),
        .OUT_COUNT    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    task automatic push(input logic [3:0] a,
                        input logic [6:0] n0, input logic [6:0] n1,
                        input logic [6:0] n2, input logic [6:0] n3,
                        input logic [6:0] v0, input logic [6:0] v1,
                        input logic [6:0] v2, input logic [6:0] v3,
                        input logic [3:0] t, input logic s, input logic [2:0] c);
        exp_t e;
        e.act   = a;
        e.note  = {n3, n2, n1, n0};
        e.vel   = {v3, v2, v1, v0};
        e.trig  = t;
        e.steal = s;
        e.cnt   = c;
        q.push_back(e);
    endtask

    task automatic push_reset();
        push(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0,
             4'b0000, 1'b0, 3'd0);
    endtask

    // Monitor: tracks handshakes and reset to know when a result is due
    int   pend = 0;
    logic fire = 1'b0;
    logic nxt  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pend = 0;
            fire = 1'b1;
        end else if (ready && all_off) begin
            fire = 1'b1;
        end else if (ready && valid) begin
            pend = 5;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) fire = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (nxt) begin
            chk("trig_low", 64'(trig), 64'd0);
            chk("steal_low", 64'(steal), 64'd0);
            nxt = 1'b0;
        end
        if (pend > 0) begin
            chk("ready_busy", 64'(ready), 64'd0);
        end
        if (fire) begin
            fire = 1'b0;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got output event expected none");
            end else begin
                e = q.pop_front();
                chk("active", 64'(active), 64'(e.act));
                chk("note", 64'(onote), 64'(e.note));
                chk("vel", 64'(ovel), 64'(e.vel));
                chk("trigger", 64'(trig), 64'(e.trig));
                chk("steal", 64'(steal), 64'(e.steal));
                chk("count", 64'(count), 64'(e.cnt));
                chk("ready_done", 64'(ready), 64'd1);
                nxt = 1'b1;
            end
        end
    end

    task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v);
        noteon = on;
        note   = n;
        vel    = v;
        valid  = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        valid   = 1'b0;
        noteon  = 1'b0;
        note    = '0;
        vel     = '0;
        all_off = 1'b0;
        push_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single note-on lands on voice 0
        push(4'b0001, 7'd60, 7'd0, 7'd0, 7'd0, 7'd100, 7'd0, 7'd0, 7'd0,
             4'b0001, 1'b0, 3'd1);
        send(1'b1, 7'd60, 7'd100);

        // Fill remaining voices, then steal the oldest
        push(4'b0011, 7'd60, 7'd62, 7'd0, 7'd0, 7'd100, 7'd100, 7'd0, 7'd0,
             4'b0010, 1'b0, 3'd2);
        send(1'b1, 7'd62, 7'd100);
        push(4'b0111, 7'd60, 7'd62, 7'd64, 7'd0, 7'd100, 7'd100, 7'd100, 7'd0,
             4'b0100, 1'b0, 3'd3);
        send(1'b1, 7'd64, 7'd100);
        push(4'b1111, 7'd60, 7'd62, 7'd64, 7'd65, 7'd100, 7'd100, 7'd100, 7'd100,
             4'b1000, 1'b0, 3'd4);
        send(1'b1, 7'd65, 7'd100);
        push(4'b1111, 7'd67, 7'd62, 7'd64, 7'd65, 7'd90, 7'd100, 7'd100, 7'd100,
             4'b0001, 1'b1, 3'd4);
        send(1'b1, 7'd67, 7'd90);

        // Ranks now (0,3,2,1): next steal is voice 1
        push(4'b1111, 7'd67, 7'd70, 7'd64, 7'd65, 7'd90, 7'd33, 7'd100, 7'd100,
             4'b0010, 1'b1, 3'd4);
        send(1'b1, 7'd70, 7'd33);

        // Reset from idle, then retrigger and velocity-zero note-off
        push_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push(4'b0001, 7'd60, 7'd0, 7'd0, 7'd0, 7'd100, 7'd0, 7'd0, 7'd0,
             4'b0001, 1'b0, 3'd1);
        send(1'b1, 7'd60, 7'd100);
        push(4'b0001, 7'd60, 7'd0, 7'd0, 7'd0, 7'd20, 7'd0, 7'd0, 7'd0,
             4'b0001, 1'b0, 3'd1);
        send(1'b1, 7'd60, 7'd20);
        push(4'b0000, 7'd60, 7'd0, 7'd0, 7'd0, 7'd20, 7'd0, 7'd0, 7'd0,
             4'b0000, 1'b0, 3'd0);
        send(1'b1, 7'd60, 7'd0);

        // Note-off for an unheld note changes nothing
        push(4'b0000, 7'd60, 7'd0, 7'd0, 7'd0, 7'd20, 7'd0, 7'd0, 7'd0,
             4'b0000, 1'b0, 3'd0);
        send(1'b0, 7'd70, 7'd64);

        push(4'b0001, 7'd61, 7'd0, 7'd0, 7'd0, 7'd50, 7'd0, 7'd0, 7'd0,
             4'b0001, 1'b0, 3'd1);
        send(1'b1, 7'd61, 7'd50);
        push(4'b0011, 7'd61, 7'd62, 7'd0, 7'd0, 7'd50, 7'd50, 7'd0, 7'd0,
             4'b0010, 1'b0, 3'd2);
        send(1'b1, 7'd62, 7'd50);
        push(4'b0111, 7'd61, 7'd62, 7'd63, 7'd0, 7'd50, 7'd50, 7'd50, 7'd0,
             4'b0100, 1'b0, 3'd3);
        send(1'b1, 7'd63, 7'd50);

        // Note-off of a middle voice
        push(4'b0101, 7'd61, 7'd62, 7'd63, 7'd0, 7'd50, 7'd50, 7'd50, 7'd0,
             4'b0000, 1'b0, 3'd2);
        send(1'b0, 7'd62, 7'd0);
        push(4'b0111, 7'd61, 7'd62, 7'd63, 7'd0, 7'd50, 7'd50, 7'd50, 7'd0,
             4'b0010, 1'b0, 3'd3);
        send(1'b1, 7'd62, 7'd50);

        // All-off with a simultaneous event: event is dropped
        push(4'b0000, 7'd61, 7'd62, 7'd63, 7'd0, 7'd50, 7'd50, 7'd50, 7'd0,
             4'b0000, 1'b0, 3'd0);
        all_off = 1'b1;
        noteon  = 1'b1;
        note    = 7'd64;
        vel     = 7'd50;
        valid   = 1'b1;
        @(negedge clk);
        chk("ready_after_alloff", 64'(ready), 64'd1);
        all_off = 1'b0;
        valid   = 1'b0;
        repeat (7) @(negedge clk);
        chk("dropped_evt_active", 64'(active), 64'd0);
        chk("dropped_evt_count", 64'(count), 64'd0);

        // Reset during SCAN discards the in-flight note-on
        noteon = 1'b1;
        note   = 7'd60;
        vel    = 7'd100;
        valid  = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        push_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push(4'b0001, 7'd61, 7'd0, 7'd0, 7'd0, 7'd70, 7'd0, 7'd0, 7'd0,
             4'b0001, 1'b0, 3'd1);
        send(1'b1, 7'd61, 7'd70);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameters: none; voice count fixed at 4, note index 7 bits, velocity 7 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset:
- IN_CLOCK  input  1  system clock, 50 MHz; all state updates on rising edge.
- IN_RESET  input  1  synchronous active-high reset.
REQ-003 The block SHALL have these ports:
- IN_EVT_VALID  input  1  event offered.
- IN_EVT_READY  output  1  block can accept an event.
- IN_EVT_NOTEON  input  1  1 = note-on, 0 = note-off.
- IN_EVT_NOTE  input  7  MIDI note / frequency table index.
- IN_EVT_VEL  input  7  velocity, 0-127.
- IN_ALL_OFF  input  1  all-notes-off request.
- OUT_ACTIVE  output  4  per-voice gate.
- OUT_NOTE  output  28  per-voice note; voice v at bits [7v+6:7v].
- OUT_VEL  output  28  per-voice velocity, same packing.
- OUT_TRIGGER  output  4  one-cycle per-voice note-start pulse.
- OUT_STEAL  output  1  one-cycle pulse when an active voice is stolen.
- OUT_COUNT  output  3  number of active voices, 0-4.

Function
REQ-004 The block SHALL use FSM states IDLE, SCAN and APPLY.
REQ-005 IN_EVT_READY SHALL be combinational and equal to (state==IDLE).
REQ-006 An event SHALL be accepted on an edge where IN_EVT_VALID && IN_EVT_READY; NOTEON, NOTE and VEL are latched at that edge and the FSM goes IDLE->SCAN with scan index 0.
REQ-007 In SCAN, one voice SHALL be examined per cycle, index 0..3. The edge that examines index 3 SHALL move the FSM to APPLY.
REQ-008 The APPLY edge SHALL write the voice table and return the FSM to IDLE.
REQ-009 Outputs SHALL reflect an event after exactly 6 edges from acceptance (accept edge plus 4 SCAN plus APPLY); the minimum event spacing is 6 cycles.
REQ-010 A note-on with IN_EVT_VEL==0 SHALL be treated as a note-off.
REQ-011 Note-on target selection SHALL follow this priority:
- (a) an active voice already holding the same note (retrigger);
- (b) else the lowest-index inactive voice;
- (c) else the voice with age rank 3 (oldest), which is a steal.
REQ-012 On note-on APPLY, the target voice SHALL set ACTIVE=1, NOTE=latched note and VEL=latched velocity. OUT_TRIGGER[target] SHALL pulse high for that one cycle. OUT_STEAL SHALL pulse only in case (c).
REQ-013 Age ranks SHALL be a permutation of 0..3 at all times. On note-on with target previous rank r, every voice with rank < r increments and the target's rank becomes 0.
REQ-014 Note-off SHALL clear ACTIVE of every active voice holding the latched note. NOTE, VEL and ranks are unchanged. A note-off for an unheld note is a no-op with no pulses.
REQ-015 IN_ALL_OFF sampled high while in IDLE SHALL clear all ACTIVE bits at that edge, with no pulses and no change to ranks.
- All-off takes priority over a simultaneous IN_EVT_VALID; IN_EVT_READY still reads 1, but the event is dropped.
- IN_ALL_OFF outside IDLE SHALL be ignored.
REQ-016 OUT_COUNT SHALL be a registered popcount of ACTIVE, consistent in the same cycle as ACTIVE.
REQ-017 OUT_TRIGGER and OUT_STEAL SHALL be low in every cycle other than the one following an APPLY edge that generated them.

Reset
REQ-018 Reset SHALL take priority over all inputs, including an event in SCAN or APPLY; an in-flight event is discarded.
REQ-019 After reset:
- state=IDLE;
- OUT_ACTIVE=0, OUT_NOTE=0, OUT_VEL=0;
- OUT_TRIGGER=0, OUT_STEAL=0, OUT_COUNT=0;
- rank of voice v = v (voice 3 oldest).

Verification
REQ-020 Reset, then note-on 60/vel 100 -> after 6 edges ACTIVE=0001, NOTE[0]=60, VEL[0]=100, TRIGGER=0001 for 1 cycle, COUNT=1; READY low for edges 1-5.
REQ-021 Note-on 60, 62, 64, 65, then 67 -> voices 0-3 filled in order; the fifth event steals voice 0 (oldest): NOTE[0]=67, STEAL pulse, TRIGGER=0001, COUNT=4.
REQ-022 Note-on 60 vel 100, then note-on 60 vel 20 -> voice 0 retriggered with VEL=20, ACTIVE=0001, no STEAL; then note-on 60 vel 0 -> ACTIVE=0000, no TRIGGER.
REQ-023 Note-off 70 with nothing held -> all outputs unchanged; IN_ALL_OFF with 3 voices active and simultaneous VALID -> ACTIVE=0000 next cycle, event dropped, FSM stays IDLE.
REQ-024 Reset asserted during SCAN of note-on 60 -> ACTIVE=0000, no TRIGGER; the next note-on 61 is allocated to voice 0 after 6 edges.
REQ-025 Randomized soak: rank vector is always a permutation of 0..3; OUT_COUNT always equals popcount(OUT_ACTIVE).
